// File: rtl/vga_timing_param.sv
// Parameterised VGA raster timing with character-cell counters and load/draw strobes.
// Optional blink generator compiled in with the VGA_TIMING_BLINK_EN macro.
module vga_timing_param #(
  parameter int unsigned H_VISIBLE    = 800,
  parameter int unsigned H_FRONT      = 56,
  parameter int unsigned H_SYNC       = 120,
  parameter int unsigned H_BACK       = 64,
  parameter int unsigned V_VISIBLE    = 600,
  parameter int unsigned V_FRONT      = 37,
  parameter int unsigned V_SYNC       = 6,
  parameter int unsigned V_BACK       = 23,
  parameter logic        HSYNC_POL    = 1'b0,
  parameter logic        VSYNC_POL    = 1'b0,
  parameter int unsigned CHAR_W       = 8,
  parameter int unsigned CHAR_H       = 10,
  parameter int unsigned LOAD_LEAD    = 7,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic [3:0]  xchar,
  output logic [4:0]  ychar,
  output logic [7:0]  xtext,
  output logic [6:0]  ytext,
  output logic        drawing,
  output logic        clk_load_char,
  output logic        clk_draw_char,
  output logic        line_start,
  output logic        frame_start,
  output logic        blink
);

  localparam int unsigned H_TOTAL   = H_BACK + H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned V_TOTAL   = V_BACK + V_VISIBLE + V_FRONT + V_SYNC;
  localparam int unsigned H_VIS_END = H_BACK + H_VISIBLE;
  localparam int unsigned V_VIS_END = V_BACK + V_VISIBLE;
  localparam int unsigned H_SYNC_ST = H_VIS_END + H_FRONT;
  localparam int unsigned V_SYNC_ST = V_VIS_END + V_FRONT;
  localparam int unsigned L_START   = H_BACK - LOAD_LEAD;
  localparam int unsigned L_END     = L_START + H_VISIBLE;

  logic [3:0]  r_lcnt;
  logic        w_x_wrap;
  logic [10:0] w_x_nxt;
  logic [10:0] w_y_nxt;
  logic        w_hvis_nxt;
  logic        w_vvis_cur;
  logic        w_vvis_nxt;
  logic        w_draw_nxt;
  logic        w_lwin_nxt;
  logic [3:0]  w_lcnt_nxt;
  logic [3:0]  w_xchar_nxt;
  logic [7:0]  w_xtext_nxt;
  logic [4:0]  w_ychar_nxt;
  logic [6:0]  w_ytext_nxt;
  logic        w_fs_nxt;

  // Every registered output is computed from the next raster position so it lines up with xpos.
  always_comb begin
    w_x_wrap   = (xpos == 11'(H_TOTAL - 1));
    w_x_nxt    = w_x_wrap ? 11'd0 : xpos + 11'd1;
    w_y_nxt    = ypos;
    if (w_x_wrap) begin
      w_y_nxt  = (ypos == 11'(V_TOTAL - 1)) ? 11'd0 : ypos + 11'd1;
    end
    w_hvis_nxt = (w_x_nxt >= 11'(H_BACK)) && (w_x_nxt < 11'(H_VIS_END));
    w_vvis_cur = (ypos >= 11'(V_BACK)) && (ypos < 11'(V_VIS_END));
    w_vvis_nxt = (w_y_nxt >= 11'(V_BACK)) && (w_y_nxt < 11'(V_VIS_END));
    w_draw_nxt = w_hvis_nxt && w_vvis_nxt;
    w_fs_nxt   = (w_x_nxt == 11'd0) && (w_y_nxt == 11'd0);

    w_xchar_nxt = 4'd0;
    w_xtext_nxt = 8'd0;
    if (w_draw_nxt && drawing) begin
      if (xchar == 4'(CHAR_W - 1)) begin
        w_xtext_nxt = xtext + 8'd1;
      end else begin
        w_xchar_nxt = xchar + 4'd1;
        w_xtext_nxt = xtext;
      end
    end

    // Row counters hold across a line and step only on the line wrap.
    w_ychar_nxt = ychar;
    w_ytext_nxt = ytext;
    if (!w_vvis_nxt || !w_vvis_cur) begin
      w_ychar_nxt = 5'd0;
      w_ytext_nxt = 7'd0;
    end else if (w_x_wrap) begin
      if (ychar == 5'(CHAR_H - 1)) begin
        w_ychar_nxt = 5'd0;
        w_ytext_nxt = ytext + 7'd1;
      end else begin
        w_ychar_nxt = ychar + 5'd1;
      end
    end

    // Load phase runs LOAD_LEAD pixels ahead of the draw phase.
    w_lwin_nxt = (w_x_nxt >= 11'(L_START)) && (w_x_nxt < 11'(L_END));
    w_lcnt_nxt = 4'd0;
    if (w_lwin_nxt && (w_x_nxt != 11'(L_START)) && (r_lcnt != 4'(CHAR_W - 1))) begin
      w_lcnt_nxt = r_lcnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xpos          <= 11'd0;
      ypos          <= 11'd0;
      hsync         <= ~HSYNC_POL;
      vsync         <= ~VSYNC_POL;
      xchar         <= 4'd0;
      xtext         <= 8'd0;
      ychar         <= 5'd0;
      ytext         <= 7'd0;
      drawing       <= 1'b0;
      clk_load_char <= 1'b0;
      clk_draw_char <= 1'b0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      r_lcnt        <= 4'd0;
    end else begin
      xpos          <= w_x_nxt;
      ypos          <= w_y_nxt;
      hsync         <= (w_x_nxt >= 11'(H_SYNC_ST)) ? HSYNC_POL : ~HSYNC_POL;
      vsync         <= (w_y_nxt >= 11'(V_SYNC_ST)) ? VSYNC_POL : ~VSYNC_POL;
      xchar         <= w_xchar_nxt;
      xtext         <= w_xtext_nxt;
      ychar         <= w_ychar_nxt;
      ytext         <= w_ytext_nxt;
      drawing       <= w_draw_nxt;
      clk_load_char <= w_lwin_nxt && (w_lcnt_nxt == 4'd0) && w_vvis_nxt;
      clk_draw_char <= w_draw_nxt && (w_xchar_nxt == 4'd0);
      line_start    <= (w_x_nxt == 11'd0);
      frame_start   <= w_fs_nxt;
      r_lcnt        <= w_lcnt_nxt;
    end
  end

`ifdef VGA_TIMING_BLINK_EN
  localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] r_fcnt;
  logic            r_blink;

  // Toggle on the frame start that closes each BLINK_FRAMES-long half-period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fcnt  <= '0;
      r_blink <= 1'b0;
    end else if (w_fs_nxt) begin
      if (r_fcnt == FC_W'(BLINK_FRAMES - 1)) begin
        r_fcnt  <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_fcnt  <= r_fcnt + FC_W'(1);
      end
    end
  end

  assign blink = r_blink;
`else
  // Frame count only matters when blinking is compiled in.
  assign blink = 1'b0 && (BLINK_FRAMES == 0);
`endif

endmodule
